retire_trace_buffer: RTL and testbench

Synthesizable retirement-trace unit for the pipelined, multi-issue processor generation. It sits beside the writeback stage, takes up to NUM_CH retired-instruction events per cycle, and classifies each as REG/LD/ST/STU/NOP/HALT. Each event gets a sequential instruction number (INUM) and is queued in a FIFO, which drains one record per cycle over a valid/ready port to the trace writer or debug link. It keeps cycle and instruction counters and tracks halt, so halt detection and the end-of-run statistics no longer rely on bench-side logic.

---
 rtl/trace_pkg.sv | 43 ++++
 rtl/trace_fifo.sv | 83 ++++++++
 rtl/retire_trace_buffer.sv | 157 +++++++++++++++
 tb/tb_retire_trace_buffer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the retirement trace unit: record kinds, the trace
// record layout and the per-lane event classifier.
package trace_pkg;

    localparam int TRC_PC_W   = 16;
    localparam int TRC_DATA_W = 16;
    localparam int TRC_ADDR_W = 16;
    localparam int TRC_REG_W  = 3;
    localparam int TRC_CNT_W  = 32;

    localparam logic [2:0] TRC_NOP  = 3'd0;
    localparam logic [2:0] TRC_REG  = 3'd1;
    localparam logic [2:0] TRC_LD   = 3'd2;
    localparam logic [2:0] TRC_ST   = 3'd3;
    localparam logic [2:0] TRC_STU  = 3'd4;
    localparam logic [2:0] TRC_HALT = 3'd5;

    // "reg" is a keyword, so the destination register field is named rd.
    typedef struct packed {
        logic [2:0]            kind;
        logic [TRC_CNT_W-1:0]  inum;
        logic [TRC_PC_W-1:0]   pc;
        logic [TRC_REG_W-1:0]  rd;
        logic [TRC_DATA_W-1:0] regval;
        logic [TRC_ADDR_W-1:0] addr;
        logic [TRC_DATA_W-1:0] memval;
    } trace_rec_t;

    function automatic logic [2:0] classify(
        input logic regwrite,
        input logic memread,
        input logic memwrite,
        input logic halt
    );
        if (regwrite && memwrite) return TRC_STU;
        if (regwrite && memread)  return TRC_LD;
        if (regwrite)             return TRC_REG;
        if (halt)                 return TRC_HALT;
        if (memwrite)             return TRC_ST;
        return TRC_NOP;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Multi-write, single-read FIFO with a registered output stage; an empty
// FIFO forwards the oldest incoming write straight into the output register.
module trace_fifo #(
    parameter int W      = 8,
    parameter int DEPTH  = 16,
    parameter int NUM_CH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          wr_en,
    input  logic [NUM_CH-1:0][W-1:0]   wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [W-1:0]               rd_data,
    output logic [CW-1:0]              count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NUM_CH + 1);

    logic [W-1:0]              mem [DEPTH];
    logic [AW-1:0]             wptr;
    logic [AW-1:0]             rptr;
    logic [CW-1:0]             mcnt;
    logic [PW-1:0]             pre [NUM_CH];
    logic [PW-1:0]             n_push;
    logic [NUM_CH-1:0][W-1:0]  cdata;
    logic                      pop;
    logic                      load;
    logic                      take;
    logic                      bypass;

    // Compact the enabled lanes so that slot k holds the k-th write in lane order.
    always_comb begin
        n_push = '0;
        cdata  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pre[i] = n_push;
            if (wr_en[i]) n_push = n_push + PW'(1);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en[i]) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (pre[i] == PW'(k)) cdata[k] = wr_data[i];
                end
            end
        end
        pop    = rd_valid && rd_ready;
        load   = !rd_valid || pop;
        take   = load && (mcnt != '0);
        bypass = load && (mcnt == '0) && (n_push != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
            wptr     <= '0;
            rptr     <= '0;
            mcnt     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (take) begin
                rd_data <= mem[rptr];
                rptr    <= rptr + AW'(1);
            end else if (bypass) begin
                rd_data <= cdata[0];
            end
            if (load) rd_valid <= take || bypass;
            // A bypassed write skips the array, so the rest shift down one slot.
            for (int k = 0; k < NUM_CH; k++) begin
                if ((PW'(k) < n_push) && (k != 0 || !bypass))
                    mem[wptr + AW'(k) - AW'(bypass)] <= cdata[k];
            end
            wptr <= wptr + AW'(n_push) - AW'(bypass);
            mcnt <= mcnt + CW'(n_push) - CW'(bypass) - CW'(take);
        end
    end

    assign count = mcnt + CW'(rd_valid);

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace unit: classifies retired lanes, numbers them, queues the
// records for the trace consumer and keeps run statistics and halt state.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16,
    parameter int PC_W   = TRC_PC_W,
    parameter int DATA_W = TRC_DATA_W,
    parameter int ADDR_W = TRC_ADDR_W,
    parameter int REG_W  = TRC_REG_W,
    parameter int CNT_W  = TRC_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       filter_nop,
    input  logic [NUM_CH-1:0]          ret_valid,
    input  logic [NUM_CH*PC_W-1:0]     ret_pc,
    input  logic [NUM_CH-1:0]          ret_regwrite,
    input  logic [NUM_CH-1:0]          ret_memread,
    input  logic [NUM_CH-1:0]          ret_memwrite,
    input  logic [NUM_CH-1:0]          ret_halt,
    input  logic [NUM_CH*REG_W-1:0]    ret_wreg,
    input  logic [NUM_CH*DATA_W-1:0]   ret_wdata,
    input  logic [NUM_CH*ADDR_W-1:0]   ret_memaddr,
    input  logic [NUM_CH*DATA_W-1:0]   ret_memdata,
    output logic                       ret_ready,
    output logic                       trc_valid,
    input  logic                       trc_ready,
    output logic [2:0]                 trc_kind,
    output logic [CNT_W-1:0]           trc_inum,
    output logic [PC_W-1:0]            trc_pc,
    output logic [REG_W-1:0]           trc_reg,
    output logic [DATA_W-1:0]          trc_regval,
    output logic [ADDR_W-1:0]          trc_addr,
    output logic [DATA_W-1:0]          trc_memval,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [CNT_W-1:0]           inst_count,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       overflow,
    output logic                       halted,
    output logic                       done
);

    localparam int PW = $clog2(NUM_CH + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CNT_W + 1;

    // Trace port handshake: a record transfers on a cycle where trc_valid and
    // trc_ready are both high; while trc_valid is high and trc_ready low the
    // record holds unchanged. ret_ready promises room for NUM_CH records.

    trace_rec_t [NUM_CH-1:0]  lane_rec;
    trace_rec_t               head;
    logic [NUM_CH-1:0]        enq;
    logic [NUM_CH-1:0]        wr_en;
    logic [PW-1:0]            n_acc;
    logic [PW-1:0]            n_enq;
    logic [PW-1:0]            n_drop;
    logic [PW-1:0]            off;
    logic [2:0]               kind;
    logic                     stop;
    logic                     halt_acc;
    logic [CW-1:0]            fifo_count;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [PW-1:0]    b
    );
        logic [SW-1:0] s;
        s = {1'b0, a} + SW'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Lanes are walked oldest first; a HALT stops every younger lane this cycle.
    always_comb begin
        stop     = halted;
        off      = '0;
        kind     = TRC_NOP;
        enq      = '0;
        n_enq    = '0;
        halt_acc = 1'b0;
        lane_rec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            kind = classify(ret_regwrite[i], ret_memread[i], ret_memwrite[i], ret_halt[i]);
            if (ret_valid[i] && !stop) begin
                lane_rec[i].kind = kind;
                lane_rec[i].inum = sat_add(inst_count, off);
                lane_rec[i].pc   = ret_pc[i*PC_W +: PC_W];
                if (kind == TRC_REG || kind == TRC_LD || kind == TRC_STU) begin
                    lane_rec[i].rd     = ret_wreg[i*REG_W +: REG_W];
                    lane_rec[i].regval = ret_wdata[i*DATA_W +: DATA_W];
                end
                if (kind == TRC_LD || kind == TRC_ST || kind == TRC_STU)
                    lane_rec[i].addr = ret_memaddr[i*ADDR_W +: ADDR_W];
                if (kind == TRC_ST || kind == TRC_STU)
                    lane_rec[i].memval = ret_memdata[i*DATA_W +: DATA_W];
                off = off + PW'(1);
                if (kind == TRC_HALT) begin
                    stop     = 1'b1;
                    halt_acc = 1'b1;
                end
                if (!(filter_nop && kind == TRC_NOP)) begin
                    enq[i] = 1'b1;
                    n_enq  = n_enq + PW'(1);
                end
            end
        end
        n_acc = off;
    end

    // Occupancy check ignores a same-cycle pop, so ret_ready is conservative.
    assign ret_ready = (fifo_count <= CW'(DEPTH - NUM_CH));
    assign wr_en     = ret_ready ? enq : '0;
    assign n_drop    = ret_ready ? '0 : n_enq;
    assign done      = halted && (fifo_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            cycle_count <= sat_add(cycle_count, PW'(1));
            inst_count  <= sat_add(inst_count, n_acc);
            drop_count  <= sat_add(drop_count, n_drop);
            if (n_drop != '0) overflow <= 1'b1;
            if (halt_acc)     halted   <= 1'b1;
        end
    end

    trace_fifo #(
        .W      ($bits(trace_rec_t)),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (lane_rec),
        .rd_valid (trc_valid),
        .rd_ready (trc_ready),
        .rd_data  (head),
        .count    (fifo_count)
    );

    assign trc_kind   = head.kind;
    assign trc_inum   = head.inum;
    assign trc_pc     = head.pc;
    assign trc_reg    = head.rd;
    assign trc_regval = head.regval;
    assign trc_addr   = head.addr;
    assign trc_memval = head.memval;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: a vector table for single-cycle
// behaviour plus hand sequences for backpressure, halt, filtering and reset.
module tb_retire_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        filter_nop = 1'b0;
    logic [1:0]  ret_valid = '0;
    logic [31:0] ret_pc = '0;
    logic [1:0]  ret_regwrite = '0;
    logic [1:0]  ret_memread = '0;
    logic [1:0]  ret_memwrite = '0;
    logic [1:0]  ret_halt = '0;
    logic [5:0]  ret_wreg = '0;
    logic [31:0] ret_wdata = '0;
    logic [31:0] ret_memaddr = '0;
    logic [31:0] ret_memdata = '0;
    logic        ret_ready;
    logic        trc_valid;
    logic        trc_ready = 1'b1;
    logic [2:0]  trc_kind;
    logic [31:0] trc_inum;
    logic [15:0] trc_pc;
    logic [2:0]  trc_reg;
    logic [15:0] trc_regval;
    logic [15:0] trc_addr;
    logic [15:0] trc_memval;
    logic [31:0] cycle_count;
    logic [31:0] inst_count;
    logic [31:0] drop_count;
    logic        overflow;
    logic        halted;
    logic        done;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]       v, rw, mr, mw, hl;
        logic [1:0][15:0] pc;
        logic [1:0][2:0]  wreg;
        logic [1:0][15:0] wdata, maddr, mdata;
        logic             e_valid;
        logic [2:0]       e_kind;
        logic [31:0]      e_inum;
        logic [15:0]      e_pc;
        logic [2:0]       e_reg;
        logic [15:0]      e_regval, e_addr, e_memval;
        logic [31:0]      e_inst;
    } vec_t;

    vec_t vecs[10];

    retire_trace_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .filter_nop   (filter_nop),
        .ret_valid    (ret_valid),
        .ret_pc       (ret_pc),
        .ret_regwrite (ret_regwrite),
        .ret_memread  (ret_memread),
        .ret_memwrite (ret_memwrite),
        .ret_halt     (ret_halt),
        .ret_wreg     (ret_wreg),
        .ret_wdata    (ret_wdata),
        .ret_memaddr  (ret_memaddr),
        .ret_memdata  (ret_memdata),
        .ret_ready    (ret_ready),
        .trc_valid    (trc_valid),
        .trc_ready    (trc_ready),
        .trc_kind     (trc_kind),
        .trc_inum     (trc_inum),
        .trc_pc       (trc_pc),
        .trc_reg      (trc_reg),
        .trc_regval   (trc_regval),
        .trc_addr     (trc_addr),
        .trc_memval   (trc_memval),
        .cycle_count  (cycle_count),
        .inst_count   (inst_count),
        .drop_count   (drop_count),
        .overflow     (overflow),
        .halted       (halted),
        .done         (done)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic clear_lanes();
        ret_valid = '0; ret_regwrite = '0; ret_memread = '0; ret_memwrite = '0;
        ret_halt = '0; ret_pc = '0; ret_wreg = '0; ret_wdata = '0;
        ret_memaddr = '0; ret_memdata = '0;
    endtask

    task automatic set_lane(input int l, input logic rw, input logic mr, input logic mw,
                            input logic hl, input logic [15:0] pc, input logic [2:0] wr,
                            input logic [15:0] wd, input logic [15:0] ma, input logic [15:0] md);
        ret_valid[l] = 1'b1;
        ret_regwrite[l] = rw;
        ret_memread[l] = mr;
        ret_memwrite[l] = mw;
        ret_halt[l] = hl;
        ret_pc[l*16 +: 16] = pc;
        ret_wreg[l*3 +: 3] = wr;
        ret_wdata[l*16 +: 16] = wd;
        ret_memaddr[l*16 +: 16] = ma;
        ret_memdata[l*16 +: 16] = md;
    endtask

    task automatic apply_vec(input vec_t t);
        for (int l = 0; l < 2; l++) begin
            ret_valid[l] = t.v[l];
            ret_regwrite[l] = t.rw[l];
            ret_memread[l] = t.mr[l];
            ret_memwrite[l] = t.mw[l];
            ret_halt[l] = t.hl[l];
            ret_pc[l*16 +: 16] = t.pc[l];
            ret_wreg[l*3 +: 3] = t.wreg[l];
            ret_wdata[l*16 +: 16] = t.wdata[l];
            ret_memaddr[l*16 +: 16] = t.maddr[l];
            ret_memdata[l*16 +: 16] = t.mdata[l];
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_lanes();
        filter_nop = 1'b0;
        trc_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
    endtask

    // Stimulus, scoreboard and report
    initial begin
        // Lane 1 is the upper half of every packed pair.
        vecs[0] = '{v:2'b01, rw:2'b01, pc:{16'h0, 16'h0000}, wreg:{3'd0, 3'd3},
                    wdata:{16'h0, 16'h00AB}, e_valid:1'b1, e_kind:3'd1, e_inum:32'd0,
                    e_reg:3'd3, e_regval:16'h00AB, e_inst:32'd1, default:0};
        vecs[1] = '{v:2'b11, rw:2'b10, mr:2'b10, mw:2'b01, pc:{16'h0004, 16'h0002},
                    wreg:{3'd5, 3'd7}, wdata:{16'h5555, 16'hDEAD}, maddr:{16'h0020, 16'h0010},
                    mdata:{16'hBEEF, 16'h1234}, e_valid:1'b1, e_kind:3'd3, e_inum:32'd1,
                    e_pc:16'h0002, e_addr:16'h0010, e_memval:16'h1234, e_inst:32'd3, default:0};
        vecs[2] = '{e_valid:1'b1, e_kind:3'd2, e_inum:32'd2, e_pc:16'h0004, e_reg:3'd5,
                    e_regval:16'h5555, e_addr:16'h0020, e_inst:32'd3, default:0};
        vecs[3] = '{v:2'b11, rw:2'b01, mw:2'b01, pc:{16'h0008, 16'h0006}, wreg:{3'd6, 3'd2},
                    wdata:{16'h1111, 16'h0BEE}, maddr:{16'h0, 16'h0030}, mdata:{16'h0, 16'h7777},
                    e_valid:1'b1, e_kind:3'd4, e_inum:32'd3, e_pc:16'h0006, e_reg:3'd2,
                    e_regval:16'h0BEE, e_addr:16'h0030, e_memval:16'h7777, e_inst:32'd5, default:0};
        vecs[4] = '{v:2'b01, rw:2'b10, mr:2'b01, pc:{16'h0, 16'h000A}, wreg:{3'd0, 3'd7},
                    wdata:{16'h0, 16'h2222}, maddr:{16'h0, 16'h0050}, e_valid:1'b1,
                    e_kind:3'd0, e_inum:32'd4, e_pc:16'h0008, e_inst:32'd6, default:0};
        vecs[5] = '{e_valid:1'b1, e_kind:3'd0, e_inum:32'd5, e_pc:16'h000A, e_inst:32'd6, default:0};
        vecs[6] = '{e_valid:1'b0, e_inst:32'd6, default:0};
        vecs[7] = '{v:2'b10, mw:2'b10, pc:{16'h000C, 16'h0}, maddr:{16'h0040, 16'h0},
                    mdata:{16'h9999, 16'h0}, e_valid:1'b1, e_kind:3'd3, e_inum:32'd6,
                    e_pc:16'h000C, e_addr:16'h0040, e_memval:16'h9999, e_inst:32'd7, default:0};
        vecs[8] = '{v:2'b11, rw:2'b11, mw:2'b01, hl:2'b01, pc:{16'h0010, 16'h000E},
                    wreg:{3'd4, 3'd1}, wdata:{16'h4444, 16'h0001}, maddr:{16'h0, 16'h0002},
                    mdata:{16'h0, 16'h0003}, e_valid:1'b1, e_kind:3'd4, e_inum:32'd7,
                    e_pc:16'h000E, e_reg:3'd1, e_regval:16'h0001, e_addr:16'h0002,
                    e_memval:16'h0003, e_inst:32'd9, default:0};
        vecs[9] = '{e_valid:1'b1, e_kind:3'd1, e_inum:32'd8, e_pc:16'h0010, e_reg:3'd4,
                    e_regval:16'h4444, e_inst:32'd9, default:0};

        // Reset state
        do_reset();
        check("rst_trc_valid", trc_valid, 0);
        check("rst_ret_ready", ret_ready, 1);
        check("rst_cycle", cycle_count, 0);
        check("rst_inst", inst_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_halted", halted, 0);
        check("rst_done", done, 0);
        check("rst_kind", trc_kind, 0);
        check("rst_inum", trc_inum, 0);
        check("rst_regval", trc_regval, 0);
        for (int i = 0; i < 3; i++) step();
        check("cycle_after_3", cycle_count, 3);

        // Vector table
        do_reset();
        for (int r = 0; r < 10; r++) begin
            apply_vec(vecs[r]);
            step();
            check($sformatf("row%0d_valid", r), trc_valid, vecs[r].e_valid);
            if (vecs[r].e_valid) begin
                check($sformatf("row%0d_kind", r), trc_kind, vecs[r].e_kind);
                check($sformatf("row%0d_inum", r), trc_inum, vecs[r].e_inum);
                check($sformatf("row%0d_pc", r), trc_pc, vecs[r].e_pc);
                check($sformatf("row%0d_reg", r), trc_reg, vecs[r].e_reg);
                check($sformatf("row%0d_regval", r), trc_regval, vecs[r].e_regval);
                check($sformatf("row%0d_addr", r), trc_addr, vecs[r].e_addr);
                check($sformatf("row%0d_memval", r), trc_memval, vecs[r].e_memval);
            end
            check($sformatf("row%0d_inst", r), inst_count, vecs[r].e_inst);
        end
        clear_lanes();

        // Dual lane from reset: ST then LD on consecutive cycles
        do_reset();
        set_lane(0, 0, 0, 1, 0, 16'h0100, 3'd0, 16'h0, 16'h0010, 16'h1234);
        set_lane(1, 1, 1, 0, 0, 16'h0102, 3'd2, 16'h0042, 16'h0018, 16'h0);
        step();
        clear_lanes();
        check("dual_kind0", trc_kind, 3);
        check("dual_inum0", trc_inum, 0);
        check("dual_addr0", trc_addr, 16'h0010);
        step();
        check("dual_kind1", trc_kind, 2);
        check("dual_inum1", trc_inum, 1);
        step();
        check("dual_empty", trc_valid, 0);

        // Backpressure and overflow
        do_reset();
        trc_ready = 1'b0;
        set_lane(0, 1, 0, 0, 0, 16'h0200, 3'd1, 16'h0001, 16'h0, 16'h0);
        step();
        exp_q.push_back(32'd0);
        for (int n = 0; n < 7; n++) begin
            check($sformatf("bp_ready_%0d", n), ret_ready, 1);
            set_lane(0, 1, 0, 0, 0, 16'h0200, 3'd1, 16'h0001, 16'h0, 16'h0);
            set_lane(1, 1, 0, 0, 0, 16'h0202, 3'd2, 16'h0002, 16'h0, 16'h0);
            step();
            exp_q.push_back(32'(2*n + 1));
            exp_q.push_back(32'(2*n + 2));
        end
        check("bp_ready_full", ret_ready, 0);
        check("bp_overflow_pre", overflow, 0);
        step();
        check("bp_overflow", overflow, 1);
        check("bp_drop", drop_count, 2);
        check("bp_inst", inst_count, 17);
        check("bp_ready_still", ret_ready, 0);
        clear_lanes();
        exp_q.push_back(32'd17);
        trc_ready = 1'b1;
        begin
            int it;
            it = 0;
            while (exp_q.size() != 0 && it < 40) begin
                if (trc_valid) check("bp_inum", trc_inum, exp_q.pop_front());
                if (it == 1) begin
                    check("bp_ready_again", ret_ready, 1);
                    set_lane(0, 1, 0, 0, 0, 16'h0300, 3'd3, 16'h0003, 16'h0, 16'h0);
                end else begin
                    clear_lanes();
                end
                step();
                it++;
            end
            clear_lanes();
            check("bp_drain_left", 32'(exp_q.size()), 0);
        end
        check("bp_empty", trc_valid, 0);
        check("bp_inst_end", inst_count, 18);
        check("bp_drop_end", drop_count, 2);
        check("bp_overflow_sticky", overflow, 1);

        // HALT masks the younger lane and everything after it
        do_reset();
        set_lane(0, 0, 0, 0, 1, 16'h0020, 3'd0, 16'h0, 16'h0, 16'h0);
        set_lane(1, 1, 0, 0, 0, 16'h0022, 3'd4, 16'h0044, 16'h0, 16'h0);
        step();
        clear_lanes();
        check("halt_kind", trc_kind, 5);
        check("halt_inum", trc_inum, 0);
        check("halt_pc", trc_pc, 16'h0020);
        check("halt_inst", inst_count, 1);
        check("halt_halted", halted, 1);
        check("halt_done_early", done, 0);
        step();
        check("halt_drained", trc_valid, 0);
        check("halt_done", done, 1);
        set_lane(0, 1, 0, 0, 0, 16'h0024, 3'd1, 16'h0011, 16'h0, 16'h0);
        step();
        clear_lanes();
        check("halt_ignore_inst", inst_count, 1);
        check("halt_ignore_valid", trc_valid, 0);
        check("halt_done_hold", done, 1);

        // NOP filtering keeps INUMs but suppresses records
        do_reset();
        filter_nop = 1'b1;
        trc_ready = 1'b0;
        set_lane(0, 0, 0, 0, 0, 16'h0400, 3'd0, 16'h0, 16'h0, 16'h0);
        step();
        set_lane(0, 1, 0, 0, 0, 16'h0402, 3'd1, 16'h0011, 16'h0, 16'h0);
        step();
        set_lane(0, 0, 0, 0, 0, 16'h0404, 3'd0, 16'h0, 16'h0, 16'h0);
        step();
        set_lane(0, 1, 0, 0, 0, 16'h0406, 3'd2, 16'h0022, 16'h0, 16'h0);
        step();
        clear_lanes();
        check("filt_inst", inst_count, 4);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd3);
        trc_ready = 1'b1;
        begin
            int it;
            it = 0;
            while (exp_q.size() != 0 && it < 10) begin
                if (trc_valid) begin
                    check("filt_kind", trc_kind, 1);
                    check("filt_inum", trc_inum, exp_q.pop_front());
                end
                step();
                it++;
            end
            check("filt_drain_left", 32'(exp_q.size()), 0);
        end
        check("filt_empty", trc_valid, 0);

        // Reset mid-drain
        do_reset();
        trc_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_lane(0, 1, 0, 0, 0, 16'h0500, 3'd1, 16'h0001, 16'h0, 16'h0);
            if (n < 2) set_lane(1, 1, 0, 0, 0, 16'h0502, 3'd2, 16'h0002, 16'h0, 16'h0);
            step();
            clear_lanes();
        end
        check("mid_inst_pre", inst_count, 5);
        check("mid_valid_pre", trc_valid, 1);
        rst = 1'b0;
        #1;
        check("mid_valid", trc_valid, 0);
        check("mid_cycle", cycle_count, 0);
        check("mid_inst", inst_count, 0);
        check("mid_drop", drop_count, 0);
        check("mid_ready", ret_ready, 1);
        step();
        rst = 1'b1;
        step();
        check("mid_cycle_after", cycle_count, 1);
        check("mid_valid_after", trc_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
